multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB phases with memory wait-state
// handshakes and a sticky trap. Optional retired-instruction counter under MCFSM_INSTRET_EN.
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] instret
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Timeout fires on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [6:0] opcode_q;
    logic [7:0] wait_q;
    logic       trap_q;
    logic [1:0] cause_q, cause_d;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
    endfunction

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                if (opcode_q == OP_BR)
                    state_d = S_FETCH;
                else if ((opcode_q == OP_LD) || (opcode_q == OP_ST))
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (opcode_q == OP_LD) ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            wait_q   <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            trap_q  <= trap_q | (state_d == S_TRAP);
            if (state_q == S_DECODE)
                opcode_q <= opcode;
            if (state_d != state_q)
                wait_q <= '0;
            else if (((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready))
                wait_q <= wait_q + 8'd1;
        end
    end

    // Reset gates every strobe so an abandoned instruction cannot emit a write during the reset cycle.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_R:  alu_op = 2'b10;
                        OP_I: begin
                            alu_op  = 2'b11;
                            alu_src = 1'b1;
                        end
                        OP_LD, OP_ST: alu_src = 1'b1;
                        OP_BR: begin
                            alu_op   = 2'b01;
                            pc_src   = 1'b1;
                            pc_write = zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_src    = 1'b1;
                    dmem_read  = (opcode_q == OP_LD);
                    dmem_write = (opcode_q == OP_ST);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode_q == OP_LD);
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

`ifdef MCFSM_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state_q == S_WB)
                  || ((state_q == S_EXEC) && (opcode_q == OP_BR))
                  || ((state_q == S_MEM) && (opcode_q == OP_ST) && dmem_ready);

    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (TIMEOUT_CYCLES=4); each row drives one cycle and
// checks {state, strobes} against a hand-computed vector.
module tb_multicycle_ctrl_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        dmem_read, dmem_write, mem_to_reg, reg_write, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

`ifdef MCFSM_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op[1:0], dmem_read, dmem_write, mem_to_reg, reg_write}
    localparam logic [10:0] SB_NONE   = 11'b00000000000;
    localparam logic [10:0] SB_F_RDY  = 11'b11100000000;
    localparam logic [10:0] SB_F_WAIT = 11'b10000000000;
    localparam logic [10:0] SB_EX_R   = 11'b00000100000;
    localparam logic [10:0] SB_EX_I   = 11'b00001110000;
    localparam logic [10:0] SB_EX_LS  = 11'b00001000000;
    localparam logic [10:0] SB_EX_BR1 = 11'b00110010000;
    localparam logic [10:0] SB_EX_BR0 = 11'b00010010000;
    localparam logic [10:0] SB_MEM_LD = 11'b00001001000;
    localparam logic [10:0] SB_MEM_ST = 11'b00001000100;
    localparam logic [10:0] SB_WB_LD  = 11'b00000000011;
    localparam logic [10:0] SB_WB     = 11'b00000000001;

    logic [10:0] strobes;
    logic [13:0] observed;
    assign strobes  = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                       dmem_read, dmem_write, mem_to_reg, reg_write};
    assign observed = {state, strobes};

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap), .trap_cause(trap_cause),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // row = {opcode[6:0], imem_ready, dmem_ready, zero, exp_state[2:0], exp_strobes[10:0]}
    function automatic logic [23:0] mk(input logic [6:0] op, input logic ir, input logic dr,
                                       input logic z, input logic [2:0] st, input logic [10:0] sb);
        return {op, ir, dr, z, st, sb};
    endfunction

    task automatic drive_cycle(input logic [23:0] row);
        @(negedge clk);
        reset      = 1'b0;
        opcode     = row[23:17];
        imem_ready = row[16];
        dmem_ready = row[15];
        zero       = row[14];
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        checks++;
        if (strobes !== SB_NONE) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected %b", strobes, SB_NONE);
        end
        @(negedge clk);
        checks++;
        if ({state, trap, trap_cause, instret} !== {3'd0, 1'b0, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got state=%0d trap=%b cause=%b instret=%0d, expected 0/0/00/0",
                     state, trap, trap_cause, instret);
        end
        exp_ret = 0;
    endtask

    task automatic check_instret(input string name);
        logic [31:0] want;
        want = INSTRET_ON ? 32'(exp_ret) : 32'd0;
        checks++;
        if (instret !== want) begin
            errors++;
            $display("FAIL %s_instret: got %0d, expected %0d", name, instret, want);
        end
    endtask

    task automatic test_rtype();
        logic [23:0] rows [5];
        rows = '{mk(OP_R,1,1,0,3'd0,SB_F_RDY), mk(OP_R,1,1,0,3'd1,SB_NONE),
                 mk(OP_R,1,1,0,3'd2,SB_EX_R),  mk(OP_R,1,1,0,3'd4,SB_WB),
                 mk(OP_R,0,1,0,3'd0,SB_F_WAIT)};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL rtype_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        exp_ret = 1;
        check_instret("rtype");
        $display("rtype: R-type sequence 0,1,2,4,0 done");
    endtask

    task automatic test_load_wait();
        logic [23:0] rows [9];
        rows = '{mk(OP_LD,1,0,0,3'd0,SB_F_RDY),  mk(OP_LD,1,0,0,3'd1,SB_NONE),
                 mk(OP_LD,1,0,0,3'd2,SB_EX_LS),  mk(OP_LD,1,0,0,3'd3,SB_MEM_LD),
                 mk(OP_LD,1,0,0,3'd3,SB_MEM_LD), mk(OP_LD,1,0,0,3'd3,SB_MEM_LD),
                 mk(OP_LD,1,1,0,3'd3,SB_MEM_LD), mk(OP_LD,1,1,0,3'd4,SB_WB_LD),
                 mk(OP_LD,0,1,0,3'd0,SB_F_WAIT)};
        test_reset();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL load_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        exp_ret = 1;
        check_instret("load");
        $display("load: 3 dmem wait cycles, 8-cycle instruction done");
    endtask

    task automatic test_branch();
        logic [23:0] rows [7];
        rows = '{mk(OP_BR,1,0,1,3'd0,SB_F_RDY), mk(OP_BR,1,0,1,3'd1,SB_NONE),
                 mk(OP_BR,1,0,1,3'd2,SB_EX_BR1), mk(OP_BR,1,0,0,3'd0,SB_F_RDY),
                 mk(OP_BR,1,0,0,3'd1,SB_NONE),  mk(OP_BR,1,0,0,3'd2,SB_EX_BR0),
                 mk(OP_BR,0,0,0,3'd0,SB_F_WAIT)};
        test_reset();
        for (int i = 0; i < 7; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL branch_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        exp_ret = 2;
        check_instret("branch");
        $display("branch: taken and not-taken branches done");
    endtask

    task automatic test_illegal();
        logic [23:0] rows [2];
        rows = '{mk(OP_BAD,1,1,0,3'd0,SB_F_RDY), mk(OP_BAD,1,1,0,3'd1,SB_NONE)};
        test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL illegal_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(mk(OP_R, 1'b1, 1'b1, 1'b1, 3'd7, SB_NONE));
            checks++;
            if ({observed, trap, trap_cause} !== {3'd7, SB_NONE, 1'b1, 2'b01}) begin
                errors++;
                $display("FAIL illegal_trap%0d: got state=%0d strobes=%b trap=%b cause=%b, expected 7/%b/1/01",
                         i, state, strobes, trap, trap_cause, SB_NONE);
            end
        end
        test_reset();
        $display("illegal: opcode 1111111 trapped with cause 01, cleared by reset");
    endtask

    task automatic test_imem_timeout();
        test_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(mk(OP_R, 1'b0, 1'b0, 1'b0, 3'd0, SB_F_WAIT));
            checks++;
            if (observed !== {3'd0, SB_F_WAIT}) begin
                errors++;
                $display("FAIL itimeout_wait%0d: got state=%0d strobes=%b, expected 0/%b", i, state, strobes, SB_F_WAIT);
            end
        end
        drive_cycle(mk(OP_R, 1'b0, 1'b0, 1'b0, 3'd7, SB_NONE));
        checks++;
        if ({state, trap, trap_cause} !== {3'd7, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL itimeout_trap: got state=%0d trap=%b cause=%b, expected 7/1/10", state, trap, trap_cause);
        end
        test_reset();
        for (int i = 0; i < 3; i++)
            drive_cycle(mk(OP_R, 1'b0, 1'b0, 1'b0, 3'd0, SB_F_WAIT));
        drive_cycle(mk(OP_R, 1'b1, 1'b0, 1'b0, 3'd0, SB_F_RDY));
        checks++;
        if (observed !== {3'd0, SB_F_RDY}) begin
            errors++;
            $display("FAIL iready_limit: got state=%0d strobes=%b, expected 0/%b", state, strobes, SB_F_RDY);
        end
        drive_cycle(mk(OP_R, 1'b1, 1'b0, 1'b0, 3'd1, SB_NONE));
        checks++;
        if ({state, trap} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL iready_decode: got state=%0d trap=%b, expected 1/0", state, trap);
        end
        $display("imem_timeout: trap after 4 waits, ready on 4th wins");
    endtask

    task automatic test_dmem_timeout();
        logic [23:0] rows [8];
        rows = '{mk(OP_LD,1,0,0,3'd0,SB_F_RDY),  mk(OP_LD,1,0,0,3'd1,SB_NONE),
                 mk(OP_LD,1,0,0,3'd2,SB_EX_LS),  mk(OP_LD,1,0,0,3'd3,SB_MEM_LD),
                 mk(OP_LD,1,0,0,3'd3,SB_MEM_LD), mk(OP_LD,1,0,0,3'd3,SB_MEM_LD),
                 mk(OP_LD,1,0,0,3'd3,SB_MEM_LD), mk(OP_LD,1,0,0,3'd7,SB_NONE)};
        test_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL dtimeout_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        checks++;
        if (trap_cause !== 2'b11) begin
            errors++;
            $display("FAIL dtimeout_cause: got %b, expected 11", trap_cause);
        end
        $display("dmem_timeout: load trapped with cause 11");
    endtask

    task automatic test_back_to_back();
        logic [23:0] rows [13];
        rows = '{mk(OP_I,1,1,0,3'd0,SB_F_RDY),  mk(OP_I,1,1,0,3'd1,SB_NONE),
                 mk(OP_I,1,1,0,3'd2,SB_EX_I),   mk(OP_I,1,1,0,3'd4,SB_WB),
                 mk(OP_ST,1,1,0,3'd0,SB_F_RDY), mk(OP_ST,1,1,0,3'd1,SB_NONE),
                 mk(OP_ST,1,1,0,3'd2,SB_EX_LS), mk(OP_ST,1,1,0,3'd3,SB_MEM_ST),
                 mk(OP_R,1,1,0,3'd0,SB_F_RDY),  mk(OP_R,1,1,0,3'd1,SB_NONE),
                 mk(OP_R,1,1,0,3'd2,SB_EX_R),   mk(OP_R,1,1,0,3'd4,SB_WB),
                 mk(OP_R,0,1,0,3'd0,SB_F_WAIT)};
        test_reset();
        for (int i = 0; i < 13; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL b2b_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        exp_ret = 3;
        check_instret("b2b");
        $display("back_to_back: I-ALU, STORE, R retired in sequence");
    endtask

    task automatic test_store_reset();
        logic [23:0] rows [5];
        rows = '{mk(OP_ST,1,0,0,3'd0,SB_F_RDY),  mk(OP_ST,1,0,0,3'd1,SB_NONE),
                 mk(OP_ST,1,0,0,3'd2,SB_EX_LS),  mk(OP_ST,1,0,0,3'd3,SB_MEM_ST),
                 mk(OP_ST,1,0,0,3'd3,SB_MEM_ST)};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(rows[i]);
            checks++;
            if (observed !== rows[i][13:0]) begin
                errors++;
                $display("FAIL streset_cyc%0d: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         i, state, strobes, rows[i][13:11], rows[i][10:0]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({dmem_write, strobes} !== {1'b0, SB_NONE}) begin
            errors++;
            $display("FAIL streset_write: got dmem_write=%b strobes=%b, expected 0/%b", dmem_write, strobes, SB_NONE);
        end
        @(negedge clk);
        checks++;
        if ({state, instret} !== {3'd0, 32'd0}) begin
            errors++;
            $display("FAIL streset_state: got state=%0d instret=%0d, expected 0/0", state, instret);
        end
        $display("store_reset: store abandoned by reset in MEM");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_back_to_back();
        test_store_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
